pc_unit: RTL

Parametrised program-counter unit for the Von Neumann core. It replaces the fixed 8-bit load-only PC with a width-generic counter that computes its own next address. It supports increment, absolute jump, conditional PC-relative branch, stall, and subroutine call/return through a hardware return-address stack (RAS). It sits between the control path, which supplies the op, target, offset and condition, and the memory address mux, which consumes `pc`.

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_unit_if.sv | 34 +++
 rtl/pc_ras.sv | 75 +++++++
 rtl/pc_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default constants for the program-counter unit.
//   pc_op_e     - 3-bit PC operation encoding driven by the control path.
//   PcAddrW     - default address width.
//   PcRasDepth  - default return-address stack depth.
//   PcResetAddr - default reset address.
package pc_pkg;

  localparam int unsigned PcAddrW     = 8;
  localparam int unsigned PcRasDepth  = 4;
  localparam int unsigned PcResetAddr = 0;

  // Values 6 and 7 are reserved; the unit treats them as HOLD and flags them.
  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_HOLD   = 3'd1,
    PC_JUMP   = 3'd2,
    PC_BRANCH = 3'd3,
    PC_CALL   = 3'd4,
    PC_RET    = 3'd5
  } pc_op_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control-path <-> PC unit bundle.
//   Control side (master) drives: en, op, target, offset, cond.
//   PC unit (slave) drives:       pc, ras_count, ras_ovf, ras_unf, illegal_op.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = PcAddrW,
  parameter int unsigned RAS_DEPTH = PcRasDepth
) ();

  localparam int unsigned CntW = cnt_width(RAS_DEPTH);

  logic              en;
  pc_op_e            op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic              cond;
  logic [ADDR_W-1:0] pc;
  logic [CntW-1:0]   ras_count;
  logic              ras_ovf;
  logic              ras_unf;
  logic              illegal_op;

  modport master (
    output en, op, target, offset, cond,
    input  pc, ras_count, ras_ovf, ras_unf, illegal_op
  );

  modport slave (
    input  en, op, target, offset, cond,
    output pc, ras_count, ras_ovf, ras_unf, illegal_op
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO).
//   clock, reset      - rising-edge clock, synchronous active-high reset.
//   push, push_data   - push an entry; when full the oldest entry is overwritten.
//   pop               - drop the top entry (ignored when empty).
//   top_data          - current top-of-stack value (valid when !empty).
//   count, full, empty- occupancy status.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = PcAddrW,
  parameter int unsigned DEPTH  = PcRasDepth
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [ADDR_W-1:0]              push_data,
  input  logic                           pop,
  output logic [ADDR_W-1:0]              top_data,
  output logic [cnt_width(DEPTH)-1:0]    count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   top_ptr;

  // Explicit wrap so non-power-of-two depths stay circular.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(DEPTH - 1) : p - PtrW'(1);
  endfunction

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign top_ptr  = ptr_dec(wr_ptr_q);
  assign top_data = mem_q[top_ptr];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      // On overflow the write lands on the oldest slot; occupancy saturates.
      if (!full) count_d = count_q + CntW'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: width-generic program counter with next-address logic.
//   clock, reset - rising-edge clock, synchronous active-high reset.
//   bus (slave)  - en/op/target/offset/cond in; pc, ras_count, ras_ovf,
//                  ras_unf, illegal_op out (all registered).
// Build option: define PC_RAS_EN to compile in the return-address stack.
// Without it CALL acts as JUMP, RET acts as HOLD and pulses illegal_op,
// and the stack status outputs are tied to zero.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = PcAddrW,
  parameter int unsigned       RAS_DEPTH  = PcRasDepth,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PcResetAddr)
) (
  input  logic       clock,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  localparam int unsigned CntW = cnt_width(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic              illegal_q, illegal_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Both sums wrap modulo 2^ADDR_W by construction.
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc_rel = pc_q + bus.offset;

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [CntW-1:0]   ras_cnt;
  logic              ras_full;
  logic              ras_empty;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .push_data (pc_inc),
    .pop       (ras_pop),
    .top_data  (ras_top),
    .count     (ras_cnt),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`endif

  always_comb begin
    pc_d      = pc_q;
    illegal_d = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
`ifdef PC_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
`endif
    if (bus.en) begin
      case (bus.op)
        PC_NEXT:   pc_d = pc_inc;
        PC_HOLD:   pc_d = pc_q;
        PC_JUMP:   pc_d = bus.target;
        PC_BRANCH: pc_d = bus.cond ? pc_rel : pc_inc;
        PC_CALL: begin
          pc_d = bus.target;
`ifdef PC_RAS_EN
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
`endif
        end
        PC_RET: begin
`ifdef PC_RAS_EN
          if (ras_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
`else
          illegal_d = 1'b1;
`endif
        end
        default:   illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_ADDR;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.illegal_op = illegal_q;

`ifdef PC_RAS_EN
  assign bus.ras_count = ras_cnt;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
`else
  assign bus.ras_count = CntW'(0);
  assign bus.ras_ovf   = 1'b0;
  assign bus.ras_unf   = 1'b0;
`endif

endmodule
